// File: rtl/seq_divider40_7_pkg.sv
// Shared arithmetic-divider definitions: default widths, FSM encoding and
// the divide-by-zero quotient pattern.
package arith_div_pkg;

  localparam int DEF_DIVIDEND_W = 40;
  localparam int DEF_DIVISOR_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam logic [DEF_DIVIDEND_W-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider40_7_if.sv
// Start/done handshake and operand/result bus between the issuing control
// FSM (master) and the sequential divider (slave).
interface seq_divider40_7_if
  import arith_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider40_7_trial_subtractor8.sv
// Combinational unsigned trial subtract for one restoring-division step;
// borrow=1 means the minuend was smaller than the subtrahend.
module trial_subtractor8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W-1:0] difference,
  output logic         borrow
);
  assign {borrow, difference} = {1'b0, minuend} - {1'b0, subtrahend};
endmodule

// File: rtl/seq_divider40_7.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle,
// with a start/done handshake toward the issuing control FSM.
module seq_divider40_7
  import arith_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input logic               clk,
  input logic               rst_n,
  seq_divider40_7_if.slave  bus
);
  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam int TW    = DIVISOR_W + 1;

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] q_reg_q, q_reg_d;
  logic [DIVISOR_W-1:0]  prem_q, prem_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [TW-1:0] trial_a, trial_b, trial_diff;
  logic          trial_borrow;
  logic          unused_diff_msb;

  // Partial remainder shifted left with the next dividend bit; one bit wider
  // than the divisor so the subtract cannot overflow.
  assign trial_a = {prem_q, q_reg_q[DIVIDEND_W-1]};
  assign trial_b = {1'b0, dvs_q};

  trial_subtractor8 #(.W(TW)) u_trial (
    .minuend    (trial_a),
    .subtrahend (trial_b),
    .difference (trial_diff),
    .borrow     (trial_borrow)
  );

  // On no-borrow the difference is below the divisor, so its MSB is always 0.
  assign unused_diff_msb = trial_diff[TW-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_reg_d = q_reg_q;
    prem_d  = prem_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            dvs_d   = bus.divisor;
            prem_d  = '0;
            q_reg_d = bus.dividend;
            cnt_d   = CNT_W'(DIVIDEND_W - 1);
            dbz_d   = 1'b0;
            state_d = ST_RUN;
          end else begin
            quot_d  = DIV0_QUOTIENT[DIVIDEND_W-1:0];
            rem_d   = bus.dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        q_reg_d = {q_reg_q[DIVIDEND_W-2:0], ~trial_borrow};
        prem_d  = trial_borrow ? trial_a[DIVISOR_W-1:0] : trial_diff[DIVISOR_W-1:0];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quot_d  = q_reg_d;
          rem_d   = prem_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_reg_q <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_reg_q <= q_reg_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider40_7.sv
// Scoreboard bench for seq_divider40_7: driver pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divider40_7;

  typedef struct {
    logic [39:0] q;
    logic [6:0]  r;
    logic        dbz;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider40_7_if bus ();

  seq_divider40_7 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   bz_from = -1;
  int   bz_to = -2;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: plain integer division, divide-by-zero rule applied directly.
  task automatic push(input logic [39:0] a, input logic [6:0] b, input int acc);
    exp_t e;
    longint unsigned la, lb;
    la = 64'(a);
    lb = 64'(b);
    if (b == 7'd0) begin
      e.q   = '1;
      e.r   = a[6:0];
      e.dbz = 1'b1;
      e.due = acc;
    end else begin
      e.q   = 40'(la / lb);
      e.r   = 7'(la % lb);
      e.dbz = 1'b0;
      e.due = acc + 40;
      bz_from = acc;
      bz_to   = acc + 39;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy", 64'(bus.busy), 64'(cyc >= bz_from && cyc <= bz_to));
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done @cyc %0d: got done=1 expected done=0", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", 64'(bus.quotient), 64'(e.q));
          chk("remainder", 64'(bus.remainder), 64'(e.r));
          chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
          chk("done_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic issue(input logic [39:0] a, input logic [6:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    push(a, b, cyc);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no done after %0d cycles, expected done", name, n);
      sb.delete();
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_quotient"}, 64'(bus.quotient), 64'd0);
    chk({tag, "_remainder"}, 64'(bus.remainder), 64'd0);
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'd0);
  endtask

  initial begin
    int acc;
    logic [39:0] a;
    logic [6:0]  b;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #2;
    chk_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(40'd1000, 7'd7);                wait_done("nominal");
    issue(40'hFF_FFFF_FFFF, 7'd127);      wait_done("max");
    issue(40'h12_3456_789A, 7'd1);        wait_done("div1");
    issue(40'd5, 7'd100);                 wait_done("small");
    issue(40'h55, 7'd0);                  wait_done("div0");
    issue(40'd9, 7'd3);                   wait_done("after_div0");
    issue(40'hAB_CDEF_0123, 7'd0);        wait_done("div0_wide");

    // Start pulses while busy must be ignored.
    issue(40'd1000, 7'd7);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 40'd12345; bus.divisor = 7'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 40'd99; bus.divisor = 7'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("start_while_busy");

    // Start held high: second accept exactly 42 edges after the first.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 40'd1000; bus.divisor = 7'd7;
    @(posedge clk);
    #1;
    acc = cyc;
    push(40'd1000, 7'd7, acc);
    bus.dividend = 40'd777; bus.divisor = 7'd5;
    while (cyc < acc + 42) begin
      @(posedge clk);
      #1;
    end
    push(40'd777, 7'd5, cyc);
    bus.start = 1'b0;
    wait_done("held_start");

    // Reset in the middle of RUN discards the operation.
    issue(40'd1000, 7'd7);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    sb.delete();
    bz_from = -1;
    bz_to   = -2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(40'd1000, 7'd7);                wait_done("post_reset");

    for (int i = 0; i < 24; i++) begin
      a = {8'($urandom_range(255, 0)), 32'($urandom())};
      b = ($urandom_range(7, 0) == 0) ? 7'd0 : 7'($urandom_range(127, 1));
      issue(a, b);
      wait_done("random");
    end

    repeat (60) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider40_7.md
# seq_divider40_7

Multi-cycle unsigned restoring divider: divides a 40-bit dividend by a 7-bit divisor and returns a 40-bit quotient and a 7-bit remainder. It undoes the 40-bit-plus-7-bit accumulation path: the arithmetic unit uses it to split a wide accumulated value back into a count and a residue. It resolves one quotient bit per cycle and uses a start/done handshake toward the issuing control FSM.

## Interface
Parameters:
- DIVIDEND_W, 40, dividend and quotient width
- DIVISOR_W, 7, divisor and remainder width

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  DIVIDEND_W  sampled on the accepted start.
- divisor  in  DIVISOR_W  sampled on the accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  DIVIDEND_W  result; holds until the next accepted start.
- remainder  out  DIVISOR_W  result; holds until the next accepted start.
- div_by_zero  out  1  flag for the last result; holds with the result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures the operands.
  - divisor≠0: clear the partial remainder, load the dividend into the quotient shift register, set counter=39, go to RUN.
  - divisor=0: go to DONE directly.
- RUN, once per cycle:
  - Form trial = {partial_rem[6:0], q_reg[39]} minus {1'b0, divisor}, 8-bit wide.
  - No borrow: partial_rem ← trial[6:0], shift 1 into q_reg LSB.
  - Borrow: partial_rem ← {partial_rem[6:0], q_reg[39]}[6:0], shift 0 into q_reg LSB.
  - Counter decrements. When the counter reaches 0 after the 40th step, go to DONE.
- Partial remainder:
  - Kept at 8 bits inside the step so the subtract never overflows.
  - The stored remainder is always < divisor, so it fits in 7 bits.
- DONE, one cycle:
  - done=1, quotient/remainder registered, return to IDLE.
- Divide-by-zero result: quotient = all ones, remainder = dividend[6:0], div_by_zero=1.
- div_by_zero is cleared on the next accepted start with a nonzero divisor.
- start in RUN or DONE is ignored; there is no queueing.
- start may be held high. A new operation is accepted on the first IDLE cycle after DONE.
- Reset mid-operation: the in-flight operation is discarded and no done is emitted.
- Output reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. State resets to IDLE.

## Timing
- Start accepted at edge N (IDLE, start=1):
  - busy=1 from N+1 through N+40.
  - done=1 for cycle N+41; results are valid from N+41.
- Divide by zero: done=1 at N+1; busy stays 0.
- Back-to-back operation: the earliest next accept is edge N+42, giving a throughput of one operation per 42 cycles.
- No combinational path from inputs to outputs.
- The trial subtract is the critical path: an 8-bit subtract per cycle.

## Structure
- Shared package `arith_div_pkg`:
  - DIVIDEND_W and DIVISOR_W defaults.
  - State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - DIV0_QUOTIENT constant (all ones).
- Sub-module `trial_subtractor8`:
  - Combinational 8-bit unsigned subtract.
  - Outputs difference[7:0] and borrow.
  - Instantiated once, mirroring the codebase's separate ripple-adder unit.
- The top level holds the FSM, the 6-bit counter, q_reg, partial_rem and the output registers.

## Test plan
- Nominal divide: dividend=1000, divisor=7 → quotient=142, remainder=6, div_by_zero=0; done exactly 41 cycles after the accepting edge; busy high 40 cycles.
- Maximum operands: dividend=40'hFF_FFFF_FFFF, divisor=127 → quotient=8657571872, remainder=31.
- Divisor 1 and dividend < divisor:
  - dividend=40'h12_3456_789A, divisor=1 → quotient=dividend, remainder=0.
  - dividend=5, divisor=100 → quotient=0, remainder=5.
- Divide by zero: dividend=0x55, divisor=0 → done 1 cycle after accept, quotient=all ones, remainder=0x55, div_by_zero=1. A following 9/3 clears div_by_zero and gives quotient=3, remainder=0.
- Start while busy:
  - Pulse start with new operands at cycles 10 and 30 of a 1000/7 run → the first result is unchanged (142, 6).
  - With start held high throughout, the second operation is accepted on the first IDLE cycle, i.e. the cycle after the done pulse, 42 cycles after the first accept.
- Reset mid-operation: assert rst_n=0 at RUN cycle 20 → all outputs 0 immediately, no done pulse; after release, a fresh 1000/7 completes correctly.
